// File: rtl/count_preload_seq_pkg.sv
// Shared types and constants for the preload sequencer.
package count_preload_seq_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  // Occupancy has to represent 0..DEPTH inclusive.
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] TERMINAL = 4'hF;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/count_preload_seq_preload_fifo.sv
// Preload FIFO: DEPTH entries of CNT_W bits with exact registered occupancy.
// A push while full is dropped even if a pop happens in the same cycle, and
// a pop on an empty FIFO is ignored (no bypass from push to head).
module preload_fifo
  import count_preload_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CNT_W-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] head,
  output logic [LVL_W-1:0] level,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (level_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Storage array; contents need no reset since level gates their use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/count_preload_seq.sv
// Preload sequencer for a downstream 4-bit loadable up counter. Values queued
// in the preload FIFO are loaded into the counter on start and at each
// terminal count; an empty FIFO at terminal count raises an underrun pulse.
// Optional feature: define COUNT_PRELOAD_SEQ_UNDERRUN_CNT_EN for a saturating
// underrun counter; otherwise underrun_cnt is tied to zero.
module count_preload_seq
  import count_preload_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_data,
  output logic             in_ready,
  input  logic [CNT_W-1:0] count,
  output logic             load,
  output logic [CNT_W-1:0] data_out,
  output logic [LVL_W-1:0] level,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  state_t state_q, state_d;
  logic   full;
  logic   push;

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

  preload_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (load),
    .head      (data_out),
    .level     (level),
    .full      (full)
  );

  // Mealy load/underrun decode and next-state selection.
  always_comb begin
    load     = 1'b0;
    underrun = 1'b0;
    state_d  = state_q;
    if (rst) begin
      state_d = IDLE;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (level != '0) begin
            load    = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (count == TERMINAL) begin
            // Load in place of the wrap when a value is queued.
            if (level != '0) begin
              load = 1'b1;
            end else begin
              underrun = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef COUNT_PRELOAD_SEQ_UNDERRUN_CNT_EN
  logic [CNT_W-1:0] ucnt_q;

  // Saturating count of underrun pulses, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (underrun && (ucnt_q != '1)) begin
      ucnt_q <= ucnt_q + CNT_W'(1);
    end
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_count_preload_seq.sv
// Bench for count_preload_seq: a queue-based model checked every cycle plus
// directed scenarios with literal expectations. Includes a model of the
// downstream loadable counter that drives the count input.
module tb_count_preload_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] count;
  logic       load;
  logic [3:0] data_out;
  logic [2:0] level;
  logic       underrun;
  logic [3:0] underrun_cnt;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  // Model state: queued values, running flag, expected counter and underrun count.
  logic [3:0] m_q[$];
  bit         m_run = 1'b0;
  logic [3:0] m_cnt = 4'h0;
  int         m_ucnt = 0;

  always #5 clk = ~clk;

  count_preload_seq dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .count        (count),
    .load         (load),
    .data_out     (data_out),
    .level        (level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // Downstream loadable up counter.
  always @(posedge clk) begin
    if (rst) count <= 4'h0;
    else if (load) count <= data_out;
    else count <= count + 4'h1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ucnt_expect(input int n);
`ifdef COUNT_PRELOAD_SEQ_UNDERRUN_CNT_EN
    return (n > 15) ? 15 : n;
`else
    return 0;
`endif
  endfunction

  // Per-cycle comparison against the model, then advance the model one edge.
  always @(negedge clk) begin
    if (armed) begin
      bit e_ready, e_load, e_under, e_push;
      logic [3:0] head;
      int sz;
      sz = m_q.size();
      head = (sz > 0) ? m_q[0] : 4'h0;
      if (rst) begin
        check("m_in_ready_rst", {7'd0, in_ready}, 8'd0);
        check("m_load_rst", {7'd0, load}, 8'd0);
        check("m_underrun_rst", {7'd0, underrun}, 8'd0);
        m_q.delete();
        m_run = 1'b0;
        m_cnt = 4'h0;
        m_ucnt = 0;
      end else begin
        e_ready = (sz < 4);
        e_load  = enable && (sz > 0) && (!m_run || m_cnt == 4'hF);
        e_under = enable && m_run && (m_cnt == 4'hF) && (sz == 0);
        e_push  = in_valid && e_ready;
        check("m_count", {4'd0, count}, {4'd0, m_cnt});
        check("m_level", {5'd0, level}, 8'(sz));
        check("m_in_ready", {7'd0, in_ready}, {7'd0, e_ready});
        check("m_load", {7'd0, load}, {7'd0, e_load});
        check("m_underrun", {7'd0, underrun}, {7'd0, e_under});
        check("m_underrun_cnt", {4'd0, underrun_cnt}, 8'(ucnt_expect(m_ucnt)));
        if (sz > 0) check("m_data_out", {4'd0, data_out}, {4'd0, head});
        if (e_load) void'(m_q.pop_front());
        if (e_push) m_q.push_back(in_data);
        m_run = enable && (m_run || e_load);
        if (e_under) m_ucnt++;
        m_cnt = e_load ? head : m_cnt + 4'h1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until count equals v, bounded.
  task automatic wait_count(input logic [3:0] v, input string name);
    int n = 0;
    while (count !== v && n < 40) begin
      cyc();
      n++;
    end
    check(name, {4'd0, count}, {4'd0, v});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    // Reset held for two cycles.
    cyc();
    armed = 1'b1;
    check("rst_load", {7'd0, load}, 8'd0);
    check("rst_level", {5'd0, level}, 8'd0);
    check("rst_in_ready", {7'd0, in_ready}, 8'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {7'd0, in_ready}, 8'd1);

    // Initial load of 2.
    enable = 1'b1; in_valid = 1'b1; in_data = 4'h2;
    cyc();
    in_valid = 1'b0;
    #1;
    check("init_load", {7'd0, load}, 8'd1);
    check("init_data", {4'd0, data_out}, 8'h2);
    check("init_level", {5'd0, level}, 8'd1);
    cyc();
    check("init_count", {4'd0, count}, 8'h2);
    check("init_level0", {5'd0, level}, 8'd0);

    // Reload with A at terminal count.
    in_valid = 1'b1; in_data = 4'hA;
    cyc();
    in_valid = 1'b0;
    wait_count(4'hF, "reload_reach_f");
    check("reload_load", {7'd0, load}, 8'd1);
    check("reload_data", {4'd0, data_out}, 8'hA);
    cyc();
    check("reload_count", {4'd0, count}, 8'hA);

    // Underrun with empty FIFO.
    wait_count(4'hF, "under_reach_f");
    check("under_pulse", {7'd0, underrun}, 8'd1);
    check("under_noload", {7'd0, load}, 8'd0);
    cyc();
    check("under_once", {7'd0, underrun}, 8'd0);
    check("under_wrap", {4'd0, count}, 8'h0);
    check("under_cnt1", {4'd0, underrun_cnt}, 8'(ucnt_expect(1)));
    for (int i = 0; i < 16; i++) begin
      wait_count(4'hF, "under_loop_f");
      cyc();
    end
    check("under_cnt17", {4'd0, underrun_cnt}, 8'(ucnt_expect(17)));

    // Back-to-back loads of F then 3.
    in_valid = 1'b1; in_data = 4'hF;
    cyc();
    in_data = 4'h3;
    cyc();
    in_valid = 1'b0;
    wait_count(4'hF, "b2b_reach_f");
    check("b2b_load1", {7'd0, load}, 8'd1);
    check("b2b_data1", {4'd0, data_out}, 8'hF);
    cyc();
    check("b2b_count_f", {4'd0, count}, 8'hF);
    check("b2b_load2", {7'd0, load}, 8'd1);
    check("b2b_data2", {4'd0, data_out}, 8'h3);
    cyc();
    check("b2b_count_3", {4'd0, count}, 8'h3);

    // Disable at terminal count: no load, back to IDLE.
    wait_count(4'hF, "dis_reach_f");
    enable = 1'b0; in_valid = 1'b1; in_data = 4'h5;
    #1;
    check("dis_noload", {7'd0, load}, 8'd0);
    check("dis_nounder", {7'd0, underrun}, 8'd0);
    cyc();
    in_valid = 1'b0; enable = 1'b1;
    #1;
    check("idle_load", {7'd0, load}, 8'd1);
    check("idle_data", {4'd0, data_out}, 8'h5);
    cyc();
    check("idle_count", {4'd0, count}, 8'h5);

    // Fill with enable low, then backpressure.
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      cyc();
    end
    in_data = 4'h9;
    #1;
    check("full_level", {5'd0, level}, 8'd4);
    check("full_ready", {7'd0, in_ready}, 8'd0);
    cyc();
    check("full_hold", {5'd0, level}, 8'd4);
    enable = 1'b1;
    #1;
    check("full_pop_load", {7'd0, load}, 8'd1);
    check("full_pop_data", {4'd0, data_out}, 8'h1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("full_after_level", {5'd0, level}, 8'd3);
    check("full_after_ready", {7'd0, in_ready}, 8'd1);

    // Reset mid-operation with three entries queued.
    rst = 1'b1;
    #1;
    check("midrst_noload", {7'd0, load}, 8'd0);
    cyc();
    check("midrst_level", {5'd0, level}, 8'd0);
    rst = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_preload_seq.md
COUNT_PRELOAD_SEQ -- requirements
Module: count_preload_seq

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  sequencing enable, level-sensitive.
- in_valid  in  1  preload value offered.
- in_data  in  4  preload value.
- in_ready  out  1  preload FIFO can accept.
- count  in  4  current value of the downstream 4-bit loadable up counter.
- load  out  1  load strobe to the counter.
- data_out  out  4  value to the counter's data_in.
- level  out  3  FIFO occupancy, 0..4.
- underrun  out  1  one-cycle pulse when a wrap occurs with the FIFO empty.
- underrun_cnt  out  4  saturating underrun count.
REQ-002 Reset SHALL be rst, synchronous, active-high, and the clock SHALL be clk.

Function
REQ-003 The block SHALL hold a 4-entry, 4-bit FIFO; a push SHALL occur on a clk edge with in_valid && in_ready.
REQ-004 in_ready SHALL equal !full && !rst; a push while full SHALL NOT occur, even if a pop happens the same cycle.
REQ-005 A pop SHALL require level>0 at cycle start; push and pop in the same cycle SHALL leave level unchanged, with no empty-FIFO bypass.
REQ-006 The block SHALL use the states IDLE and RUN.
REQ-007 In IDLE with enable=1 and level>0: load=1, data_out=FIFO head, pop, next state RUN.
REQ-008 In IDLE with enable=1 and level=0: load=0 and the block SHALL stay in IDLE.
REQ-009 In RUN with count==4'hF and level>0, the block SHALL assert load=1 with data_out=head and pop the same cycle, so the counter loads instead of wrapping.
REQ-010 In RUN with count==4'hF and level=0: load=0, underrun=1 for that cycle, stay in RUN (counter free-wraps to 0).
REQ-011 In RUN with count!=4'hF: load=0.
REQ-012 load SHALL be a combinational (Mealy) function of state, enable, count and level; data_out SHALL be the FIFO head at all times, with don't-care content when level=0.
REQ-013 A preload value of 4'hF SHALL cause load again on the next cycle if level>0, giving back-to-back loads.
REQ-014 enable=0 SHALL force load=0 and underrun=0 combinationally; the next state SHALL be IDLE; FIFO contents and pushes SHALL be unaffected.
REQ-015 level SHALL be registered and exact, 0..4, and SHALL never wrap.

Reset
REQ-016 On rst: state=IDLE, FIFO empty, level=0, load=0, underrun=0, underrun_cnt=0, in_ready=0.
REQ-017 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-018 rst mid-operation SHALL discard all FIFO entries, with no load issued in the rst cycle.

Configuration
REQ-019 With COUNT_PRELOAD_SEQ_UNDERRUN_CNT_EN defined, underrun_cnt SHALL increment on each underrun pulse, saturate at 4'hF, and clear only on rst.
REQ-020 Without the macro, underrun_cnt SHALL be tied to 4'h0 and no counter register SHALL be synthesized; the underrun pulse SHALL be unaffected.

Structure
REQ-021 Package count_preload_seq_pkg SHALL hold the state typedef (IDLE, RUN) and the constants DEPTH=4, CNT_W=4 and TERMINAL=4'hF.
REQ-022 The FIFO SHALL be a sub-module preload_fifo (push/pop/head/level/full), instantiated once.

Verification
REQ-023 Reset: rst high for 2 cycles -> load=0, level=0, in_ready=0 during rst; in_ready=1 on the first cycle after.
REQ-024 Initial load: enable=1, push 4'h2 -> next cycle load=1, data_out=2, level 1->0, state RUN; the counter then counts 2..F.
REQ-025 Reload at terminal: push 4'hA while the counter runs; at count==F -> load=1, data_out=A; the next count is A, not 0.
REQ-026 Underrun: FIFO empty, count reaches F -> underrun=1 for exactly one cycle, load=0, counter wraps to 0; with the macro, underrun_cnt 0->1; 17 underruns -> underrun_cnt=F.
REQ-027 Full/backpressure: push 4 values with enable=0 -> level=4, in_ready=0; a 5th in_valid is not accepted; enable=1 -> pop, in_ready=1 next cycle.
REQ-028 Edge cases:
- Push 4'hF then 4'h3 in RUN -> loads on consecutive cycles (F then 3).
- Deassert enable at count==F -> no load, IDLE next cycle.
- rst with level=3 -> level=0.
